// File: rtl/apb_uart_fifo_pkg.sv
// Shared definitions for the APB UART: register offsets, STATUS/CTRL bit positions, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_apb_pkg;

  // Register select, taken from paddr[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  // STATUS bit positions
  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_RX_FULL     = 1;
  localparam int ST_TX_EMPTY    = 2;
  localparam int ST_TX_FULL     = 3;
  localparam int ST_TX_BUSY     = 4;
  localparam int ST_RX_OVERRUN  = 5;
  localparam int ST_FRAME_ERR   = 6;
  localparam int ST_TX_OVERFLOW = 7;
  localparam int ST_RX_COUNT    = 8;

  // CTRL bit positions
  localparam int CT_TX_EN   = 0;
  localparam int CT_RX_EN   = 1;
  localparam int CT_STOP2   = 2;
  localparam int CT_IE_RX   = 3;
  localparam int CT_IE_TX   = 4;
  localparam int CT_IE_ERR  = 5;
  localparam int CT_CLR_ERR = 6;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/apb_uart_fifo_if.sv
// APB3 bus bundle between the fabric (master) and the UART (slave).
// Latency: n/a (wires only).
// Backpressure: none; the slave always answers in the access phase.
interface apb_uart_fifo_if;
  logic        in_psel;
  logic        in_penable;
  logic [2:0]  in_pprot;
  logic [31:0] in_paddr;
  logic        in_pwrite;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic [31:0] in_prdata;
  logic        in_pready;
  logic        in_pslverr;

  modport master (
    output in_psel, in_penable, in_pprot, in_paddr, in_pwrite, in_pwdata, in_pstrb,
    input  in_prdata, in_pready, in_pslverr
  );

  modport slave (
    input  in_psel, in_penable, in_pprot, in_paddr, in_pwrite, in_pwdata, in_pstrb,
    output in_prdata, in_pready, in_pslverr
  );
endinterface

// File: rtl/apb_uart_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Latency: a push is visible on rdata_o the cycle after it is written.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  // A pop frees the slot a same-cycle push needs, so full+pop+push succeeds
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage array, written on accepted push
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  // Pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/apb_uart_fifo.sv
// APB3 UART with TX/RX FIFOs, programmable baud divisor, sticky errors and a level interrupt.
// Latency: APB zero wait states; irq registered one cycle after its sources.
// Backpressure: none on APB; full TX FIFO drops writes (tx_overflow), full RX FIFO drops frames (rx_overrun).
module apb_uart_fifo
  import uart_apb_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int OVS       = 16,
  parameter int DIV_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  apb_uart_fifo_if.slave    apb,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic              irq
);
  localparam int TCW = $clog2(2*OVS);
  localparam int BCW = $clog2(DATA_BITS);

  logic              access, slverr, acc_ok, wr_ok, rd_ok, div_wr, clr_err, tick;
  logic [1:0]        reg_sel;
  logic [5:0]        ctrl_q, ctrl_d;
  logic [DIV_W-1:0]  div_q, div_d, baud_q, baud_d;
  logic              ovr_q, ovr_d, frm_q, frm_d, txo_q, txo_d, irq_q, irq_d;
  logic [31:0]       status, prdata;
  logic              tx_push, tx_pop, tx_full, tx_empty, tx_go, tx_last;
  logic              rx_push, rx_pop, rx_full, rx_empty, rx_ovr_set, rx_frm_set;
  logic [DATA_BITS-1:0] tx_rdata, rx_rdata, tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic              rx_meta_q, rx_sync_q, rx_prev_q, txd_q, txd_d;
  tx_state_e         tx_state_q, tx_state_d;
  rx_state_e         rx_state_q, rx_state_d;
  logic [TCW-1:0]    tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [BCW-1:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic              unused_bits;

  // Bus decode: errors suppress every side effect of the access
  assign access  = apb.in_psel & apb.in_penable;
  assign reg_sel = apb.in_paddr[3:2];
  assign slverr  = (|apb.in_paddr[11:4]) | (apb.in_pwrite & (reg_sel == REG_STATUS));
  assign acc_ok  = access & ~slverr;
  assign wr_ok   = acc_ok & apb.in_pwrite & apb.in_pstrb[0];
  assign rd_ok   = acc_ok & ~apb.in_pwrite;
  assign div_wr  = wr_ok & (reg_sel == REG_DIV);
  assign tx_push = wr_ok & (reg_sel == REG_DATA);
  assign rx_pop  = rd_ok & (reg_sel == REG_DATA) & ~rx_empty;
  assign apb.in_pready  = access;
  assign apb.in_pslverr = access & slverr;
  assign apb.in_prdata  = prdata;
  assign uart_tx = txd_q;
  assign irq     = irq_q;
  assign tick    = (baud_q == '0);
  assign unused_bits = ^{apb.in_pprot, apb.in_paddr, apb.in_pwdata, apb.in_pstrb, tx_count};

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock(clock), .reset(reset), .push_i(tx_push), .wdata_i(apb.in_pwdata[DATA_BITS-1:0]),
    .pop_i(tx_pop), .rdata_o(tx_rdata), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count));

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock(clock), .reset(reset), .push_i(rx_push), .wdata_i(rx_shift_q),
    .pop_i(rx_pop), .rdata_o(rx_rdata), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count));

  // Register writes, sticky error flags (a new event beats clr_err), baud counter, irq source
  always_comb begin
    ctrl_d  = ctrl_q;
    div_d   = div_q;
    clr_err = 1'b0;
    if (wr_ok && reg_sel == REG_CTRL) begin
      ctrl_d  = apb.in_pwdata[5:0];
      clr_err = apb.in_pwdata[CT_CLR_ERR];
    end
    if (div_wr) div_d = apb.in_pwdata[DIV_W-1:0];
    ovr_d  = rx_ovr_set | (ovr_q & ~clr_err);
    frm_d  = rx_frm_set | (frm_q & ~clr_err);
    txo_d  = (tx_push & tx_full & ~tx_pop) | (txo_q & ~clr_err);
    baud_d = div_wr ? apb.in_pwdata[DIV_W-1:0] : (tick ? div_q : baud_q - DIV_W'(1));
    irq_d  = (ctrl_q[CT_IE_RX] & ~rx_empty) | (ctrl_q[CT_IE_TX] & tx_empty) |
             (ctrl_q[CT_IE_ERR] & (ovr_q | frm_q | txo_q));
  end

  // STATUS word and read mux; prdata is zero outside a good read access
  always_comb begin
    status = '0;
    status[ST_RX_NONEMPTY] = ~rx_empty;
    status[ST_RX_FULL]     = rx_full;
    status[ST_TX_EMPTY]    = tx_empty;
    status[ST_TX_FULL]     = tx_full;
    status[ST_TX_BUSY]     = (tx_state_q != TX_IDLE);
    status[ST_RX_OVERRUN]  = ovr_q;
    status[ST_FRAME_ERR]   = frm_q;
    status[ST_TX_OVERFLOW] = txo_q;
    status[ST_RX_COUNT+7:ST_RX_COUNT] = 8'(rx_count);
    prdata = '0;
    if (rd_ok) begin
      case (reg_sel)
        REG_DATA:   prdata = rx_empty ? '0 : 32'(rx_rdata);
        REG_STATUS: prdata = status;
        REG_CTRL:   prdata = 32'(ctrl_q);
        default:    prdata = 32'(div_q);
      endcase
    end
  end

  // TX next state: pop on entry to START, LSB first, optional double stop, no gap between frames
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    tx_go      = ctrl_q[CT_TX_EN] & ~tx_empty;
    tx_last    = (tx_state_q == TX_STOP && ctrl_q[CT_STOP2]) ? (tx_cnt_q == TCW'(2*OVS-1))
                                                              : (tx_cnt_q == TCW'(OVS-1));
    if (tx_state_q == TX_IDLE) begin
      if (tx_go) begin
        tx_state_d = TX_START;
        tx_pop     = 1'b1;
        tx_shift_d = tx_rdata;
        tx_cnt_d   = '0;
      end
    end else if (tick) begin
      if (!tx_last) begin
        tx_cnt_d = tx_cnt_q + TCW'(1);
      end else begin
        tx_cnt_d = '0;
        case (tx_state_q)
          TX_START: begin
            tx_state_d = TX_DATA;
            tx_bit_d   = '0;
          end
          TX_DATA: begin
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + BCW'(1);
            if (tx_bit_q == BCW'(DATA_BITS-1)) tx_state_d = TX_STOP;
          end
          default: begin
            if (tx_go) begin
              tx_state_d = TX_START;
              tx_pop     = 1'b1;
              tx_shift_d = tx_rdata;
            end else begin
              tx_state_d = TX_IDLE;
            end
          end
        endcase
      end
    end
    txd_d = (tx_state_d == TX_START) ? 1'b0 : (tx_state_d == TX_DATA) ? tx_shift_d[0] : 1'b1;
  end

  // RX next state: glitch-checked start, mid-bit data samples, single stop sample
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    rx_ovr_set = 1'b0;
    rx_frm_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (ctrl_q[CT_RX_EN] && rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_cnt_q == TCW'(OVS/2-1)) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_d = rx_cnt_q + TCW'(1);
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_cnt_q == TCW'(OVS-1)) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            rx_bit_d   = rx_bit_q + BCW'(1);
            if (rx_bit_q == BCW'(DATA_BITS-1)) rx_state_d = RX_STOP;
          end else begin
            rx_cnt_d = rx_cnt_q + TCW'(1);
          end
        end
      end
      default: begin
        if (tick) begin
          if (rx_cnt_q == TCW'(OVS-1)) begin
            rx_cnt_d   = '0;
            rx_state_d = RX_IDLE;
            if (!rx_sync_q)                rx_frm_set = 1'b1;
            else if (rx_full && !rx_pop)   rx_ovr_set = 1'b1;
            else                           rx_push    = 1'b1;
          end else begin
            rx_cnt_d = rx_cnt_q + TCW'(1);
          end
        end
      end
    endcase
  end

  // State registers; the serial output resets straight to idle-high
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q     <= '0;
      div_q      <= '0;
      baud_q     <= '0;
      ovr_q      <= 1'b0;
      frm_q      <= 1'b0;
      txo_q      <= 1'b0;
      irq_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      baud_q     <= baud_d;
      ovr_q      <= ovr_d;
      frm_q      <= frm_d;
      txo_q      <= txo_d;
      irq_q      <= irq_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
    end
  end
endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed bench for apb_uart_fifo with TX/RX byte scoreboards.
// Latency: n/a.
// Backpressure: n/a.
module tb_apb_uart_fifo;
  logic clock = 1'b0;
  logic reset;
  logic uart_rx;
  logic uart_tx;
  logic irq;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  int   rx_model_cnt = 0;

  apb_uart_fifo_if bus();

  apb_uart_fifo dut (
    .clock(clock), .reset(reset), .apb(bus),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic err, output logic rdy);
    @(posedge clock); #1;
    bus.in_psel = 1'b1; bus.in_penable = 1'b0; bus.in_paddr = addr;
    bus.in_pwrite = wr; bus.in_pwdata = wdata; bus.in_pstrb = strb;
    @(posedge clock); #1;
    bus.in_penable = 1'b1;
    #3;
    rdata = bus.in_prdata; err = bus.in_pslverr; rdy = bus.in_pready;
    @(posedge clock); #1;
    bus.in_psel = 1'b0; bus.in_penable = 1'b0; bus.in_pwrite = 1'b0;
  endtask

  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] d; logic e; logic r;
    apb_xfer(1'b1, addr, wdata, 4'hF, d, e, r);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d; logic e; logic r;
    apb_xfer(1'b0, addr, 32'h0, 4'h0, d, e, r);
    check(tag, d, exp);
  endtask

  task automatic tx_send(input logic [7:0] b);
    tx_exp_q.push_back(b);
    apb_wr(32'h0, {24'h0, b});
  endtask

  // Records the serial line cycle by cycle from the first start bit and counts
  // deviations from the ideal 16-cycle-per-bit waveform of the scoreboard bytes.
  task automatic tx_capture(input int nframes, output int mism, output logic seen);
    logic [7:0] cur;
    logic       expv;
    int         pos;
    seen = 1'b0; mism = 0; cur = 8'h00;
    for (int w = 0; w < 600 && !seen; w++) begin
      @(posedge clock); #1;
      if (uart_tx === 1'b0) seen = 1'b1;
    end
    if (seen) begin
      for (int k = 0; k < nframes*160 + 10; k++) begin
        if (k > 0) begin @(posedge clock); #1; end
        if (k % 160 == 0 && k / 160 < nframes)
          cur = (tx_exp_q.size() != 0) ? tx_exp_q.pop_front() : 8'h00;
        pos = k % 160;
        if (k >= nframes*160) expv = 1'b1;
        else if (pos < 16)    expv = 1'b0;
        else if (pos < 144)   expv = cur[(pos-16)/16];
        else                  expv = 1'b1;
        if (uart_tx !== expv) mism++;
      end
    end
  endtask

  // Drives one frame at 32 cycles per bit; model records what the FIFO should hold
  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    if (stop && rx_model_cnt < 16) begin
      rx_exp_q.push_back(b);
      rx_model_cnt++;
    end
    @(posedge clock); #1;
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      repeat (32) @(posedge clock);
      #1;
    end
    uart_rx = 1'b1;
  endtask

  task automatic rx_read_check(input string tag);
    logic [31:0] exp;
    exp = 32'h0;
    if (rx_exp_q.size() != 0) begin
      exp = {24'h0, rx_exp_q.pop_front()};
      rx_model_cnt--;
    end
    rd_check(tag, 32'h0, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic        e, r, seen;
    int          mism;

    reset = 1'b1; uart_rx = 1'b1;
    bus.in_psel = 1'b0; bus.in_penable = 1'b0; bus.in_pprot = 3'b000; bus.in_paddr = '0;
    bus.in_pwrite = 1'b0; bus.in_pwdata = '0; bus.in_pstrb = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // 1. reset state
    check("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("reset_irq", {31'h0, irq}, 32'h0);
    apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, d, e, r);
    check("reset_status", d, 32'h4);
    check("read_pready", {31'h0, r}, 32'h1);
    check("read_pslverr", {31'h0, e}, 32'h0);
    rd_check("reset_data_empty", 32'h0, 32'h0);
    rd_check("reset_div", 32'hC, 32'h0);

    // 2. single TX frame, DIV=0 -> 16 cycles per bit
    apb_wr(32'hC, 32'h0);
    apb_wr(32'h8, 32'h01);
    fork
      tx_capture(1, mism, seen);
      begin
        tx_send(8'hA5);
        repeat (60) @(posedge clock);
        rd_check("tx_busy_status", 32'h4, 32'h14);
      end
    join
    check("tx_start_seen", {31'h0, seen}, 32'h1);
    check("tx_wave_a5", mism, 0);
    rd_check("tx_done_status", 32'h4, 32'h4);

    // back-to-back frames with no idle gap
    fork
      tx_capture(2, mism, seen);
      begin tx_send(8'h5A); tx_send(8'h0F); end
    join
    check("tx2_start_seen", {31'h0, seen}, 32'h1);
    check("tx_wave_b2b", mism, 0);

    // 3. RX single frame, DIV=1 -> 32 cycles per bit
    apb_wr(32'hC, 32'h1);
    apb_wr(32'h8, 32'h02);
    rd_check("div_readback", 32'hC, 32'h1);
    rx_send(8'h3C, 1'b1);
    repeat (10) @(posedge clock);
    rd_check("rx_one_status", 32'h4, 32'h105);
    rx_read_check("rx_data_3c");
    rd_check("rx_drained_status", 32'h4, 32'h4);

    // 4. overrun: 17 frames into a 16-entry FIFO
    for (int i = 0; i < 17; i++) rx_send(8'(i*37 + 5), 1'b1);
    repeat (10) @(posedge clock);
    rd_check("rx_overrun_status", 32'h4, 32'h1027);
    apb_wr(32'h8, 32'h42);
    rd_check("clr_err_status", 32'h4, 32'h1007);
    rd_check("ctrl_clr_selfclear", 32'h8, 32'h02);
    for (int i = 0; i < 16; i++) rx_read_check($sformatf("rx_fifo_%0d", i));
    rd_check("rx_all_read_status", 32'h4, 32'h4);
    rd_check("rx_empty_read", 32'h0, 32'h0);

    // 5. framing error, then irq latency on enable and on clear
    rx_send(8'h55, 1'b0);
    repeat (10) @(posedge clock);
    rd_check("frame_err_status", 32'h4, 32'h44);
    check("irq_masked", {31'h0, irq}, 32'h0);
    apb_wr(32'h8, 32'h22);
    check("irq_lat_rise_0", {31'h0, irq}, 32'h0);
    @(posedge clock); #1;
    check("irq_lat_rise_1", {31'h0, irq}, 32'h1);
    apb_wr(32'h8, 32'h62);
    check("irq_lat_fall_0", {31'h0, irq}, 32'h1);
    @(posedge clock); #1;
    check("irq_lat_fall_1", {31'h0, irq}, 32'h0);
    rd_check("err_cleared_status", 32'h4, 32'h4);

    // 6. slave errors and ignored writes
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, d, e, r);
    check("bad_addr_pslverr", {31'h0, e}, 32'h1);
    check("bad_addr_prdata", d, 32'h0);
    apb_xfer(1'b1, 32'h4, 32'hFF, 4'hF, d, e, r);
    check("wr_status_pslverr", {31'h0, e}, 32'h1);
    rd_check("wr_status_nochange", 32'h4, 32'h4);
    apb_xfer(1'b1, 32'h0, 32'h77, 4'b0010, d, e, r);
    check("strb_pslverr", {31'h0, e}, 32'h0);
    rd_check("strb_no_push", 32'h4, 32'h4);
    apb_xfer(1'b1, 32'h18, 32'h5, 4'hF, d, e, r);
    check("bad_addr_wr_pslverr", {31'h0, e}, 32'h1);
    rd_check("bad_addr_wr_div", 32'hC, 32'h1);

    // 7. TX overflow, then reset in the middle of a frame
    apb_wr(32'hC, 32'h0);
    apb_wr(32'h8, 32'h00);
    for (int i = 0; i < 17; i++) apb_wr(32'h0, 32'(i));
    rd_check("tx_overflow_status", 32'h4, 32'h88);
    apb_wr(32'h8, 32'h01);
    repeat (5) @(posedge clock);
    #1 check("tx_low_before_reset", {31'h0, uart_tx}, 32'h0);
    #2 reset = 1'b1;
    #1 check("tx_high_async_reset", {31'h0, uart_tx}, 32'h1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    rd_check("post_reset_status", 32'h4, 32'h4);
    rd_check("post_reset_ctrl", 32'h8, 32'h0);
    check("post_reset_irq", {31'h0, irq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_uart_fifo.md
Name: apb_uart_fifo

Overview:
Parametrised APB3 UART: zero-wait-state APB slave with programmable baud divisor, independent TX/RX FIFOs, 8N1-style serial engines with configurable data bits and stop bits, sticky error flags and one level-sensitive interrupt.
Sits on the peripheral APB fabric as the next-generation console/serial port, replacing the byte-register 16550 wrapper.
It adds FIFOs, error reporting and slave errors.

Parameters:
DATA_BITS, 8, serial data bits per frame (5..8).
TX_DEPTH, 16, TX FIFO entries (power of two, >=2).
RX_DEPTH, 16, RX FIFO entries (power of two, >=2).
OVS, 16, oversampling ticks per bit (even, >=4).
DIV_W, 16, baud divisor width.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_psel  in  1  APB select
in_penable  in  1  APB enable
in_pprot  in  3  ignored
in_paddr  in  32  byte address; [3:2] selects register
in_pwrite  in  1  write
in_pwdata  in  32  write data
in_pstrb  in  4  byte strobes; a write needs pstrb[0]=1 or it is ignored
in_prdata  out  32  read data
in_pready  out  1  = psel & penable
in_pslverr  out  1  error response
uart_rx  in  1  serial input, asynchronous
uart_tx  out  1  serial output
irq  out  1  interrupt, level-high

Behaviour:
- Reset values: uart_tx=1, irq=0, in_prdata=0, in_pslverr=0. CTRL=0. DIV=0. FIFOs empty. Error flags 0. FSMs IDLE.
- APB access completes in the access phase (psel&penable), with no wait states. Side effects (push, pop, clear) occur once, on that cycle's clock edge.
- prdata is combinational in the access phase and 0 otherwise.
- Register map:
  - 0x0 DATA. Write pushes pwdata[DATA_BITS-1:0] to TX. Read pops RX and returns the byte zero-extended. Reading with RX empty returns 0 and does not pop.
  - 0x4 STATUS, read-only. Bits: [0] rx_nonempty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] tx_busy, [5] rx_overrun, [6] frame_err, [7] tx_overflow, [15:8] rx_count.
  - 0x8 CTRL, RW. Bits: [0] tx_en, [1] rx_en, [2] stop2, [3] ie_rx, [4] ie_tx, [5] ie_err, [6] clr_err (write-1 self-clearing; clears bits 5..7).
  - 0xC DIV, RW, [DIV_W-1:0].
- pslverr=1 in these cases; the access has no side effect:
  - paddr[11:4]!=0;
  - write to STATUS.
- Baud tick: counter reloads at DIV and pulses tick when it reaches 0. Tick period is DIV+1 cycles; bit time is OVS ticks. A DIV write resets the counter.
- TX FSM states IDLE→START→DATA→STOP→IDLE.
  - IDLE→START when tx_en and FIFO not empty. The pop happens on that transition.
  - Data is sent LSB first. Each state lasts OVS ticks; STOP lasts 2*OVS if stop2.
  - Back-to-back frames have no idle gap.
  - Clearing tx_en mid-frame finishes the current frame.
  - Pushing to a full TX FIFO drops the data and sets tx_overflow.
- RX: uart_rx passes through a 2-flop synchroniser (reset value 1).
- RX FSM states IDLE→START→DATA→STOP.
  - IDLE→START on a synchronised falling edge when rx_en.
  - At OVS/2 ticks, START re-samples the line. If it is high (a glitch), return to IDLE.
  - DATA samples every OVS ticks at mid-bit. STOP samples once.
  - Stop=0: set frame_err, discard the byte, go to IDLE.
  - Stop=1 with RX FIFO full: set rx_overrun, discard the byte.
  - Otherwise push the byte.
- FIFO: simultaneous push and pop allowed at every occupancy. At full, a pop plus a push both succeed and the count is unchanged. At empty, a push plus a pop with no valid data does not pop.
- Simultaneous clr_err and a new error event: the event wins and the flag stays 1.
- irq = (ie_rx & rx_nonempty) | (ie_tx & tx_empty) | (ie_err & (rx_overrun|frame_err|tx_overflow)). irq is registered, one cycle latency.
- Reset asserted mid-frame: uart_tx=1 immediately (asynchronous); all state returns to its reset values.

Decomposition:
- Package uart_apb_pkg holds:
  - register offsets;
  - STATUS/CTRL bit-index constants;
  - TX/RX FSM state enums.
- Sub-module uart_sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count), instantiated once for TX and once for RX.

Test Plan:
1. Reset, then read 0x4 → 0x0004 (tx_empty only). Read 0x0 → 0. uart_tx=1.
2. DIV=0, CTRL=0x01, write 0x0 data 0xA5 → uart_tx low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high. tx_busy=1 throughout.
3. DIV=1, CTRL=0x02, drive frame 0x3C on uart_rx at 32 cycles/bit → STATUS[0]=1, rx_count=1. Read 0x0 → 0x3C. Next STATUS[0]=0.
4. Drive 17 frames with RX_DEPTH=16 and no reads → rx_count=16, rx_overrun=1. Write CTRL clr_err → bit 5=0, data preserved.
5. Frame with stop bit=0 → frame_err=1, no push. With ie_err=1, irq=1 one cycle after the flag.
6. Read 0x10 → pslverr=1, prdata=0. Write STATUS → pslverr=1, no change. Write 0x0 with pstrb=4'b0010 → no push.
